// File: rtl/mul_booth_r4_unit_pkg.sv
// Shared definitions for the radix-4 Booth multiplier: RISC-V op encodings,
// controller states and the number of Booth steps for a given operand width.
package mul_pkg;

    typedef enum logic [1:0] {
        MUL_OP_MUL    = 2'b00,
        MUL_OP_MULH   = 2'b01,
        MUL_OP_MULHSU = 2'b10,
        MUL_OP_MULHU  = 2'b11
    } mul_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } mul_state_e;

    // Operands are widened by two bits, so each retires two bits per step.
    function automatic int booth_steps(input int xlen);
        return xlen / 2 + 1;
    endfunction

endpackage

// File: rtl/mul_booth_r4_unit_core.sv
// Radix-4 Booth datapath: shifted multiplicand, retiring multiplier,
// accumulator and step counter. One recoded digit is added per cycle.
module mul_booth_r4_core
    import mul_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              kill,
    input  logic [XLEN+1:0]   a_ext,
    input  logic [XLEN+1:0]   b_ext,
    output logic              done,
    output logic [2*XLEN-1:0] product
);

    localparam int EW    = XLEN + 2;
    localparam int ACC_W = 2 * XLEN + 4;
    localparam int CNT_W = $clog2(XLEN / 2 + 2);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_next;
    logic [ACC_W-1:0] mcand;
    logic [ACC_W-1:0] addend;
    logic [EW-1:0]    mplier;
    logic             prev;
    logic [CNT_W-1:0] count;

    // Booth recoding of the 3-bit window {b[2i+1], b[2i], b[2i-1]}.
    always_comb begin
        addend = '0;
        case ({mplier[1:0], prev})
            3'b001, 3'b010: addend = mcand;
            3'b011:         addend = mcand << 1;
            3'b100:         addend = -(mcand << 1);
            3'b101, 3'b110: addend = -mcand;
            default:        addend = '0;
        endcase
        acc_next = acc + addend;
    end

    // Exposing the post-add sum lets the controller capture the product on the final step edge.
    assign done    = (count == CNT_W'(1));
    assign product = acc_next[2*XLEN-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            prev   <= 1'b0;
            count  <= '0;
        end else if (kill) begin
            count <= '0;
        end else if (start) begin
            acc    <= '0;
            mcand  <= {{(ACC_W-EW){a_ext[EW-1]}}, a_ext};
            mplier <= b_ext;
            prev   <= 1'b0;
            count  <= CNT_W'(booth_steps(XLEN));
        end else if (count != '0) begin
            acc    <= acc_next;
            mcand  <= mcand << 2;
            mplier <= {{2{mplier[EW-1]}}, mplier[EW-1:2]};
            prev   <= mplier[1];
            count  <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/mul_booth_r4_unit.sv
// Iterative radix-4 Booth multiplier for the execute stage: RISC-V MUL/MULH/
// MULHSU/MULHU, tag passthrough, zero-operand early-out and output backpressure.
module mul_booth_r4_unit
    import mul_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int TAG_W     = 5,
    parameter int EARLY_OUT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_hi,
    output logic [XLEN-1:0]  out_lo,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    mul_state_e          state;
    logic                zero_r;
    logic [TAG_W-1:0]    tag_r;
    logic                sign_a;
    logic                sign_b;
    logic [XLEN+1:0]     a_ext;
    logic [XLEN+1:0]     b_ext;
    logic                start;
    logic                kill;
    logic                core_done;
    logic [2*XLEN-1:0]   product;

    // Two extra bits turn every op into a signed*signed product of the widened operands.
    always_comb begin
        sign_a = (in_op != MUL_OP_MULHU) && in_a[XLEN-1];
        sign_b = ((in_op == MUL_OP_MUL) || (in_op == MUL_OP_MULH)) && in_b[XLEN-1];
        a_ext  = {{2{sign_a}}, in_a};
        b_ext  = {{2{sign_b}}, in_b};
    end

    assign start    = (state == IDLE) && in_valid && !flush;
    assign kill     = flush || ((state == CALC) && zero_r);
    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    mul_booth_r4_core #(
        .XLEN (XLEN)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .kill    (kill),
        .a_ext   (a_ext),
        .b_ext   (b_ext),
        .done    (core_done),
        .product (product)
    );

    // Results are only published on entry to DONE, so a flushed op never leaks a partial sum.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            zero_r    <= 1'b0;
            tag_r     <= '0;
            out_valid <= 1'b0;
            out_hi    <= '0;
            out_lo    <= '0;
            out_tag   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= CALC;
                        tag_r  <= in_tag;
                        zero_r <= (EARLY_OUT != 0) && ((in_a == '0) || (in_b == '0));
                    end
                end
                CALC: begin
                    if (flush) begin
                        state <= IDLE;
                    end else if (zero_r) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        out_hi    <= '0;
                        out_lo    <= '0;
                        out_tag   <= tag_r;
                    end else if (core_done) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        out_hi    <= product[2*XLEN-1:XLEN];
                        out_lo    <= product[XLEN-1:0];
                        out_tag   <= tag_r;
                    end
                end
                DONE: begin
                    if (out_ready || flush) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
